calc_cmd_sequencer: RTL

// - Sits in front of the calculator core and is the only driver of its 4-bit cmd input.
// - Arbitrates key codes from two requesters, keypad and host/test port, queues them in a

---
 rtl/calc_cmd_sequencer_if.sv | 29 ++
 rtl/calc_cmd_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_cmd_sequencer_if
// Request-side handshake bundle for calc_cmd_sequencer: the keypad and the
// host/test port each offer a 4-bit key code with a valid/ready pair.
//   key_valid  / host_valid  : requester -> sequencer, code offered
//   key_cmd    / host_cmd    : requester -> sequencer, 4-bit key code
//   key_ready  / host_ready  : sequencer -> requester, code accepted this cycle
// Modports:
//   master : requester side (drives valid/cmd, observes ready)
//   slave  : sequencer side (observes valid/cmd, drives ready)
// ---------------------------------------------------------------------------
interface calc_cmd_sequencer_if;
    logic       key_valid;
    logic [3:0] key_cmd;
    logic       key_ready;
    logic       host_valid;
    logic [3:0] host_cmd;
    logic       host_ready;

    modport master (
        output key_valid, key_cmd, host_valid, host_cmd,
        input  key_ready, host_ready
    );

    modport slave (
        input  key_valid, key_cmd, host_valid, host_cmd,
        output key_ready, host_ready
    );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// calc_cmd_sequencer
// Sole driver of the calculator core's 4-bit cmd input. Round-robin
// arbitrates key codes from the keypad and the host port, queues them in a
// small FIFO, and issues one code at a time paced on the core status
// (00 error, 01 busy, 10 ready, 11 printing). Flags core errors and hangs.
//
// Ports:
//   clock        in   rising-edge system clock
//   reset        in   asynchronous, active-high
//   req          slave modport of calc_cmd_sequencer_if (keypad/host handshakes)
//   calc_status  in   [1:0] core status
//   calc_cmd     out  [3:0] command to core, NOP_CMD when not issuing
//   err_clr      in   leave ERR state (1-cycle pulse)
//   fifo_level   out  [$clog2(DEPTH):0] queued entries
//   busy         out  FSM not IDLE, or FIFO not empty
//   err          out  core reported status 00
//   timeout      out  hang detected
//   issued_cnt   out  [15:0] issue counter, only when SEQ_STATS_EN is defined
//
// Optional feature macro: SEQ_STATS_EN (adds issued_cnt).
// ---------------------------------------------------------------------------
module calc_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ACK_WIN = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [3:0]  NOP_CMD = 4'hD
) (
    input  logic                     clock,
    input  logic                     reset,
    calc_cmd_sequencer_if.slave      req,
    input  logic [1:0]               calc_status,
    output logic [3:0]               calc_cmd,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     err,
    output logic                     timeout
`ifdef SEQ_STATS_EN
    ,
    output logic [15:0]              issued_cnt
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [7:0]  ACK_LAST = 8'(ACK_WIN - 1);
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [1:0]  ST_ERROR = 2'b00;
    localparam logic [1:0]  ST_READY = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic        full, empty;
    logic        grant_key, grant_host, accept_ok;
    logic        push, pop, flush;
    logic [3:0]  push_data;
    logic        rr_last_host;
    logic [7:0]  wait_cnt;
    logic        set_err, set_to, clr_err;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // ---------------- arbitration ----------------
    // With both requesters valid, the one not granted last wins.
    assign grant_key  = req.key_valid  && (!req.host_valid || rr_last_host);
    assign grant_host = req.host_valid && (!req.key_valid  || !rr_last_host);
    assign accept_ok  = !full && (state != S_ERR);

    assign req.key_ready  = grant_key  && accept_ok;
    assign req.host_ready = grant_host && accept_ok;

    assign push      = req.key_ready || req.host_ready;
    assign push_data = grant_host ? req.host_cmd : req.key_cmd;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_last_host <= 1'b1;
        end else if (push) begin
            rr_last_host <= grant_host;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign fifo_level = level;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        calc_cmd  = NOP_CMD;
        pop       = 1'b0;
        flush     = 1'b0;
        set_err   = 1'b0;
        set_to    = 1'b0;
        clr_err   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!empty && calc_status == ST_READY) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                calc_cmd  = mem[rd_ptr];
                pop       = 1'b1;
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Only READY keeps us here, so wait_cnt doubles as the count
                // of consecutive READY cycles since issue.
                if (calc_status[0]) begin
                    state_nxt = S_WAIT_DONE;
                end else if (calc_status == ST_READY && wait_cnt == ACK_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (calc_status == ST_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_nxt = S_IDLE;
                    clr_err   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Hang: this is the TIMEOUT-th wait cycle after issue.
        if ((state == S_WAIT_ACK || state == S_WAIT_DONE) && wait_cnt == TO_LAST) begin
            state_nxt = S_ERR;
            set_to    = 1'b1;
            flush     = 1'b1;
        end

        // Core error overrides everything, including a coincident hang.
        if (state != S_ERR && calc_status == ST_ERROR) begin
            state_nxt = S_ERR;
            set_err   = 1'b1;
            set_to    = 1'b0;
            flush     = 1'b1;
        end
    end

    // ---------------- wait counter (saturating) ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT_ACK || state == S_WAIT_DONE) && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // ---------------- flags ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err     <= 1'b0;
            timeout <= 1'b0;
        end else if (clr_err) begin
            err     <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (set_err) begin
                err <= 1'b1;
            end
            if (set_to) begin
                timeout <= 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE) || !empty;

`ifdef SEQ_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_cnt <= '0;
        end else if (state == S_ISSUE) begin
            issued_cnt <= issued_cnt + 1'b1;
        end
    end
`endif

endmodule
